// File: rtl/fht_adc_loader.sv
// ADC-to-FHT bank loader: writes a frame of samples across bit-reversed RAM banks, then kicks the FHT core.
// Optional macro FHT_LOADER_BIAS_EN subtracts a signed DC offset (iBIAS) from each sample.
module fht_adc_loader #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 8,
  parameter int BANKS = 4
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iARM,
  input  logic                    iCONT,
  input  logic signed [D_BIT-2:0] iDATA,
  input  logic                    iVALID,
  output logic                    oREADY,
  input  logic signed [D_BIT-2:0] iBIAS,
  input  logic                    iFHT_RDY,
  output logic signed [D_BIT-1:0] oDATA,
  output logic [A_BIT-1:0]        oADDR_WR,
  output logic [BANKS-1:0]        oWE,
  output logic                    oSTART,
  output logic                    oBUSY,
  output logic                    oOVF,
  output logic [7:0]              oFRAME_CNT
);
  localparam int B_BIT = $clog2(BANKS);
  localparam int K_BIT = A_BIT + B_BIT;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_FHT} state_t;
  state_t state, state_nxt;

  logic [1:0]              rst_sync;
  logic                    run;
  logic [K_BIT-1:0]        k;
  logic [1:0]              wait_cnt;
  logic                    vld_p0;
  logic                    last_p0;
  logic                    fht_done;
  logic                    arm_go;
  logic signed [D_BIT-1:0] word_p0;
  logic signed [D_BIT-1:0] data_p1;
  logic [A_BIT-1:0]        addr_p1;
  logic [BANKS-1:0]        we_p1;
  logic                    ovf;
  logic [7:0]              frame_cnt;

  function automatic logic signed [D_BIT-1:0] sext(input logic signed [D_BIT-2:0] x);
    return {x[D_BIT-2], x};
  endfunction

  // Bank group taken from the top of k is bit-reversed before one-hot decode.
  function automatic logic [BANKS-1:0] bank_sel(input logic [B_BIT-1:0] grp);
    logic [B_BIT-1:0] rev;
    for (int i = 0; i < B_BIT; i++) rev[i] = grp[B_BIT-1-i];
    return BANKS'(1) << rev;
  endfunction

  // Arming is held off until reset release has crossed two flops.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

`ifdef FHT_LOADER_BIAS_EN
  assign word_p0 = sext(iDATA) - sext(iBIAS);
`else
  logic unused_bias;
  assign unused_bias = ^iBIAS;
  assign word_p0     = sext(iDATA);
`endif

  assign vld_p0   = iVALID && (state == LOAD);
  assign last_p0  = vld_p0 && (k == '1);
  assign fht_done = (state == WAIT_FHT) && (wait_cnt == 2'd2) && iFHT_RDY;
  assign arm_go   = (state == IDLE) && iARM && run;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (arm_go)   state_nxt = LOAD;
      LOAD:     if (last_p0)  state_nxt = START;
      START:                  state_nxt = WAIT_FHT;
      WAIT_FHT: if (fht_done) state_nxt = iCONT ? LOAD : IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    oREADY = (state == LOAD);
    oBUSY  = (state != IDLE);
    oSTART = (state == START);
  end

  // p0 -> p1: accepted sample registered onto the RAM write port.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      k         <= '0;
      wait_cnt  <= '0;
      ovf       <= 1'b0;
      frame_cnt <= '0;
      we_p1     <= '0;
      addr_p1   <= '0;
      data_p1   <= '0;
    end else begin
      we_p1 <= '0;
      if (arm_go || fht_done) k <= '0;
      else if (vld_p0)        k <= k + K_BIT'(1);
      if (vld_p0) begin
        we_p1   <= bank_sel(k[K_BIT-1 -: B_BIT]);
        addr_p1 <= k[A_BIT-1:0];
        data_p1 <= word_p0;
      end
      if (arm_go)                                      ovf <= 1'b0;
      else if (iVALID && (state == START || state == WAIT_FHT)) ovf <= 1'b1;
      if (state == START)                              wait_cnt <= '0;
      else if (state == WAIT_FHT && wait_cnt != 2'd2)  wait_cnt <= wait_cnt + 2'd1;
      if (fht_done) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign oWE        = we_p1;
  assign oADDR_WR   = addr_p1;
  assign oDATA      = data_p1;
  assign oOVF       = ovf;
  assign oFRAME_CNT = frame_cnt;
endmodule

// File: tb/tb_fht_adc_loader.sv
// Randomized bench for fht_adc_loader against a frame-level reference model of the loader rules.
module tb_fht_adc_loader;
  localparam int D_BIT     = 16;
  localparam int A_BIT     = 8;
  localparam int BANKS     = 4;
  localparam int BANK_SIZE = 1 << A_BIT;
  localparam int TOTAL     = BANKS * BANK_SIZE;
`ifdef FHT_LOADER_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_LOAD = 1, M_START = 2, M_WAIT = 3;

  logic iCLK = 1'b0, iRESET = 1'b0, iARM = 1'b0, iCONT = 1'b0, iVALID = 1'b0, iFHT_RDY = 1'b0;
  logic signed [D_BIT-2:0] iDATA = '0, iBIAS = '0;
  logic oREADY, oSTART, oBUSY, oOVF;
  logic signed [D_BIT-1:0] oDATA;
  logic [A_BIT-1:0] oADDR_WR;
  logic [BANKS-1:0] oWE;
  logic [7:0] oFRAME_CNT;

  always #5 iCLK = ~iCLK;

  fht_adc_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .BANKS(BANKS)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iARM(iARM), .iCONT(iCONT), .iDATA(iDATA),
    .iVALID(iVALID), .oREADY(oREADY), .iBIAS(iBIAS), .iFHT_RDY(iFHT_RDY),
    .oDATA(oDATA), .oADDR_WR(oADDR_WR), .oWE(oWE), .oSTART(oSTART),
    .oBUSY(oBUSY), .oOVF(oOVF), .oFRAME_CNT(oFRAME_CNT)
  );

  int n_checks = 0, n_fail = 0, n_start = 0;
  int m_phase, m_n, m_wcnt, m_frames, m_we, m_addr;
  bit m_ovf;
  logic [15:0] m_data;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Bank for the n-th sample of a frame: bit-reversed group number.
  function automatic int bank_of(input int n);
    int g = n / BANK_SIZE;
    int r = 0;
    for (int w = BANKS; w > 1; w = w / 2) begin
      r = r * 2 + (g % 2);
      g = g / 2;
    end
    return r;
  endfunction

  function automatic int exp_word(input int d, input int b);
    return BIAS_EN ? (d - b) : d;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_n = 0; m_wcnt = 0; m_frames = 0;
    m_we = 0; m_addr = 0; m_ovf = 1'b0; m_data = 16'h0;
  endtask

  task automatic check_all();
    check_eq("oWE",        32'(oWE),        32'(m_we));
    check_eq("oADDR_WR",   32'(oADDR_WR),   32'(m_addr));
    check_eq("oDATA",      {16'd0, oDATA},  {16'd0, m_data});
    check_eq("oOVF",       32'(oOVF),       32'(m_ovf));
    check_eq("oFRAME_CNT", 32'(oFRAME_CNT), 32'(m_frames));
    check_eq("oSTART",     32'(oSTART),     32'(m_phase == M_START));
    check_eq("oBUSY",      32'(oBUSY),      32'(m_phase != M_IDLE));
    check_eq("oREADY",     32'(oREADY),     32'(m_phase == M_LOAD));
  endtask

  // Drive one cycle at the falling edge, advance the model, check after the next rising edge.
  task automatic tick(input bit arm, input bit vld, input int d, input int b, input bit rdy, input bit cont);
    logic signed [D_BIT-2:0] ds, bs;
    bit acc;
    ds = (D_BIT-1)'(d); bs = (D_BIT-1)'(b);
    iARM = arm; iVALID = vld; iDATA = ds; iBIAS = bs; iFHT_RDY = rdy; iCONT = cont;
    acc  = vld && (m_phase == M_LOAD);
    m_we = 0;
    case (m_phase)
      M_IDLE: if (arm) begin m_phase = M_LOAD; m_n = 0; m_ovf = 1'b0; end
      M_LOAD: if (acc) begin
        m_we   = 1 << bank_of(m_n);
        m_addr = m_n % BANK_SIZE;
        m_data = 16'(exp_word(int'(ds), int'(bs)));
        m_n++;
        if (m_n == TOTAL) begin m_n = 0; m_phase = M_START; end
      end
      M_START: begin if (vld) m_ovf = 1'b1; m_wcnt = 0; m_phase = M_WAIT; end
      default: begin
        if (vld) m_ovf = 1'b1;
        if (m_wcnt >= 2 && rdy) begin
          m_frames = (m_frames + 1) % 256;
          m_phase  = cont ? M_LOAD : M_IDLE;
        end else m_wcnt++;
      end
    endcase
    @(posedge iCLK);
    @(negedge iCLK);
    if (oSTART === 1'b1) n_start++;
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, since;
    bit seen, vld, acc_first;
    model_reset();
    #2 check_all();
    @(negedge iCLK); @(negedge iCLK);
    iRESET = 1'b1;
    // Idle with iVALID high: must neither accept nor flag overflow.
    for (int i = 0; i < 4; i++) tick(0, 1, $urandom, 0, 0, 0);

    // Ramp frame: iDATA = k, iVALID held high.
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TOTAL; i++) tick(0, 1, i, 0, 0, 0);
    check_eq("start_with_last_we", 32'(oSTART), 32'd1);
    // iFHT_RDY high from the start, samples arriving while waiting.
    for (int c = 0; c < 20 && m_phase != M_IDLE; c++) tick(0, 1, $urandom, 0, 1, 0);
    check_eq("ramp_end_busy", 32'(oBUSY), 32'd0);
    check_eq("ovf_after_wait", 32'(oOVF), 32'd1);
    check_eq("frame_cnt_1", 32'(oFRAME_CNT), 32'd1);

    // Re-arm clears overflow; then abandon a partial frame with an async reset.
    tick(1, 0, 0, 0, 0, 0);
    check_eq("ovf_cleared_by_arm", 32'(oOVF), 32'd0);
    for (int i = 0; i < 300; i++) tick(0, 1, $urandom, $urandom, 0, 0);
    #2 iRESET = 1'b0;
    #1 model_reset();
    check_all();
    s0 = n_start;
    @(negedge iCLK);
    iRESET = 1'b1;
    for (int i = 0; i < 4; i++) tick(0, 1, $urandom, 0, 1, 1);
    check_eq("no_start_after_reset", 32'(n_start - s0), 32'd0);

    // Continuous mode: two frames from one arm, random gaps, FHT ready ~20 cycles after start.
    s0 = n_start; seen = 1'b0; since = 0;
    tick(1, 0, 0, 0, 0, 1);
    for (int c = 0; c < 9000 && m_phase != M_IDLE; c++) begin
      vld = ($urandom_range(0, 3) != 0);
      if (m_phase == M_START) since = 0;
      else if (m_phase == M_WAIT) since++;
      acc_first = !seen && vld && (m_phase == M_LOAD);
      tick(0, vld, seen ? int'($urandom) : -1, seen ? int'($urandom) : 0,
           (m_phase == M_WAIT) && since >= 20,
           (m_phase == M_WAIT) ? (m_frames < 1) : 1'($urandom_range(0, 1)));
      if (acc_first) begin
        seen = 1'b1;
        check_eq("first_we_bank0", 32'(oWE), 32'd1);
        check_eq("first_addr0", 32'(oADDR_WR), 32'd0);
        check_eq("neg_one_sext", {16'd0, oDATA}, 32'h0000FFFF);
      end
    end
    check_eq("cont_end_busy", 32'(oBUSY), 32'd0);
    check_eq("cont_two_starts", 32'(n_start - s0), 32'd2);
    check_eq("cont_frame_cnt_2", 32'(oFRAME_CNT), 32'd2);

    // Offset subtraction corners (plain sign extension when the feature is off).
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 50, 100, 0, 0);
    check_eq("bias_50_100", {16'd0, oDATA}, BIAS_EN ? 32'h0000FFCE : 32'h00000032);
    tick(0, 1, -16384, 16383, 0, 0);
    check_eq("bias_extreme", {16'd0, oDATA}, BIAS_EN ? 32'h00008001 : 32'h0000C000);
    tick(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
